// File: rtl/ddc_pkg.sv
// Shared constants and types for the DDC output-path blocks.
package ddc_pkg;

    localparam int IN_W    = 48;
    localparam int OUT_W   = 16;
    localparam int SHIFT_W = 6;

    // Window-decision sequencer states
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        LOD,
        DECIDE
    } state_t;

    // Signed saturation limits of an OUT_W-bit sample
    localparam longint SAT_HI = (longint'(1) <<< (OUT_W - 1)) - 1;
    localparam longint SAT_LO = -(longint'(1) <<< (OUT_W - 1));

endpackage

// File: rtl/lod48.sv
// Registered 48-bit leading-one detector: index of the highest set bit
// plus a flag that is high when the input is all zeros.
module lod48 (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] value,
    output logic [5:0]  index,
    output logic        zero
);

    logic [5:0] index_c;

    // Scan upward so the last set bit found is the highest one
    always_comb begin
        index_c = '0;
        for (int i = 0; i < 48; i++) begin
            if (value[i]) index_c = 6'(i);
        end
    end

    // Register the result so the priority chain stays off the decision path
    always_ff @(posedge clk) begin
        if (rst) begin
            index <= '0;
            zero  <= 1'b1;
        end else begin
            index <= index_c;
            zero  <= (value == '0);
        end
    end

endmodule

// File: rtl/ddc_auto_scale.sv
// Window-based automatic requantizer: picks a right shift from the peak
// detector once per window (fast attack, slow release) and applies it to
// the 48-bit sample stream, saturating to OUT_W bits.
// Optional feature macro: AUTO_SCALE_SAT_CNT_EN (per-window saturation count).
//
// Qualifier semantics: there is no backpressure. A sample is taken on every
// clock edge where data_valid is high; data_out_valid is high for exactly one
// cycle per taken sample, one cycle later. data_out holds otherwise.
module ddc_auto_scale #(
    parameter int IN_W        = ddc_pkg::IN_W,
    parameter int OUT_W       = ddc_pkg::OUT_W,
    parameter int HEADROOM    = 1,
    parameter int MAX_SHIFT   = 32,
    parameter int PEAK_DELAY  = 4,
    parameter int DEC_WINDOWS = 4,
    parameter int INIT_SHIFT  = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ms_in,
    input  logic [IN_W-1:0]             peak,
    input  logic signed [IN_W-1:0]      data_in,
    input  logic                        data_valid,
    output logic signed [OUT_W-1:0]     data_out,
    output logic                        data_out_valid,
    output logic [ddc_pkg::SHIFT_W-1:0] shift,
    output logic                        shift_valid,
    output logic [15:0]                 sat_count
);

    import ddc_pkg::*;

    localparam int DEC_W = $clog2(DEC_WINDOWS + 1);
    localparam logic signed [IN_W-1:0]  LIM_HI  = IN_W'(SAT_HI);
    localparam logic signed [IN_W-1:0]  LIM_LO  = IN_W'(SAT_LO);
    localparam logic signed [OUT_W-1:0] OUT_MAX = OUT_W'(SAT_HI);
    localparam logic signed [OUT_W-1:0] OUT_MIN = OUT_W'(SAT_LO);

    state_t             state;
    logic               ms_d;
    logic               win_edge;
    logic [3:0]         wait_cnt;
    logic [IN_W-1:0]    peak_r;
    logic [5:0]         lod_index;
    logic               lod_zero;
    logic [DEC_W-1:0]   dec_cnt;
    logic [SHIFT_W-1:0] tgt;
    int                 p_i;
    int                 t_i;

    logic signed [IN_W-1:0] shifted;
    logic                   sat_hi;
    logic                   sat_lo;

    assign win_edge = ms_in & ~ms_d;

    // Delay the strobe by one cycle for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) ms_d <= 1'b0;
        else     ms_d <= ms_in;
    end

    lod48 u_lod (
        .clk   (clk),
        .rst   (rst),
        .value (peak_r),
        .index (lod_index),
        .zero  (lod_zero)
    );

    // Target shift from peak position: keep HEADROOM spare bits above the peak
    always_comb begin
        p_i = lod_zero ? -1 : int'(lod_index);
        t_i = p_i + 1 + HEADROOM - (OUT_W - 1);
        if (t_i < 0)         t_i = 0;
        if (t_i > MAX_SHIFT) t_i = MAX_SHIFT;
        tgt = SHIFT_W'(t_i);
    end

    // Window decision sequencer; edges seen outside IDLE are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            peak_r      <= '0;
            shift       <= SHIFT_W'(INIT_SHIFT);
            dec_cnt     <= '0;
            shift_valid <= 1'b0;
        end else begin
            shift_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_edge) begin
                        state    <= WAIT;
                        wait_cnt <= 4'd1;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'(PEAK_DELAY)) begin
                        peak_r <= peak;
                        state  <= LOD;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                LOD: begin
                    state <= DECIDE;
                end
                DECIDE: begin
                    shift_valid <= 1'b1;
                    state       <= IDLE;
                    if (tgt > shift) begin
                        shift   <= tgt;
                        dec_cnt <= '0;
                    end else if (tgt == shift) begin
                        dec_cnt <= '0;
                    end else if (dec_cnt == DEC_W'(DEC_WINDOWS - 1)) begin
                        shift   <= shift - SHIFT_W'(1);
                        dec_cnt <= '0;
                    end else begin
                        dec_cnt <= dec_cnt + DEC_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign shifted = data_in >>> shift;
    assign sat_hi  = (shifted > LIM_HI);
    assign sat_lo  = (shifted < LIM_LO);

    // Shift and saturate each valid sample; output holds when not valid
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            data_out_valid <= data_valid;
            if (data_valid) begin
                if (sat_hi)      data_out <= OUT_MAX;
                else if (sat_lo) data_out <= OUT_MIN;
                else             data_out <= shifted[OUT_W-1:0];
            end
        end
    end

`ifdef AUTO_SCALE_SAT_CNT_EN
    logic [15:0] sat_acc;
    logic        sat_now;

    assign sat_now = data_valid & (sat_hi | sat_lo);

    // Count saturations per window; a hit on the edge cycle opens the new window
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_acc   <= '0;
            sat_count <= '0;
        end else if (win_edge) begin
            sat_count <= sat_acc;
            sat_acc   <= sat_now ? 16'd1 : 16'd0;
        end else if (sat_now && sat_acc != 16'hFFFF) begin
            sat_acc <= sat_acc + 16'd1;
        end
    end
`else
    assign sat_count = '0;
`endif

endmodule
